// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU memory port: responder states, byte-offset width
// and error codes reserved for a future multi-bit error field.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTE_OFFSET_W = 2;

  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

// File: rtl/word_ram.sv
// Word-addressed RAM: synchronous write, combinational read, no reset so contents
// survive a responder reset.
module word_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: accepts one request, holds it for
// LATENCY edges, then commits/reads the RAM and presents a response until consumed.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
      $error("mem_responder: ADDR_WIDTH must be in 1..29");
    end
  endgenerate

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_count;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  r_write;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_misalign;
  logic                  w_range;
  logic                  w_err;
  logic                  w_finish;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_misalign = |r_addr[BYTE_OFFSET_W-1:0];
  assign w_range    = |r_addr[31:ADDR_WIDTH+BYTE_OFFSET_W];
  assign w_err      = w_misalign | w_range;
  assign w_finish   = (r_state == WAIT) && (r_count == 4'd0);
  // Gated by reset_n so a reset landing on the commit edge drops the write.
  assign w_commit   = reset_n && w_finish && r_write && !w_err;

  word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_commit),
    .i_addr (r_addr[ADDR_WIDTH+BYTE_OFFSET_W-1:BYTE_OFFSET_W]),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_count      <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_count     <= COUNT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= (w_err || r_write) ? '0 : w_ram_rdata;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rdata      <= '0;
            r_err        <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
